// File: rtl/eq_pkg.sv
// eq_pkg: shared definitions for the equaliser divider sequencer.
//   - default geometry (NSC, IDX_W, DIV_LAT) and the derived tag pipeline depth
//   - FSM state enum and the tag carried alongside each sample
package eq_pkg;

    localparam int unsigned NSC_DEF     = 64;
    localparam int unsigned IDX_W_DEF   = 6;
    localparam int unsigned DIV_LAT_DEF = 8;

    // Tag index field is sized for the widest supported IDX_W; the top uses the low bits.
    localparam int unsigned TAG_IDX_W = 16;

    // Stage 1 (RAM read), stage 2 (estimate return), one product stage, then the divider.
    function automatic int unsigned pipe_depth(input int unsigned div_lat);
        return 3 + div_lat;
    endfunction

    localparam int unsigned PIPE_DEF = pipe_depth(DIV_LAT_DEF);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
        logic                 last;
        logic                 zero;
    } tag_t;

endpackage

// File: rtl/eq_tag_pipe.sv
// eq_tag_pipe: DEPTH-stage shift register of tags with asynchronous active-low clear.
//   i_clk    clock
//   i_rst_n  asynchronous clear, active low (all stages cleared, so nothing in flight survives)
//   i_tag    tag entering stage 0
//   o_tag    tag leaving the last stage, DEPTH cycles later
module eq_tag_pipe
    import eq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  tag_t i_tag,
    output tag_t o_tag
);

    tag_t r_stage [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/eq_div_sched.sv
// eq_div_sched: per-symbol sequencer for the equaliser complex divider.
// Accepts NSC samples per symbol, reads the matching channel estimate, feeds the divider
// and realigns its quotient with valid / index / end-of-symbol tags.
// Optional feature macro: EQ_ZERO_GUARD_EN (force 0 output and flag m_zero on 0+0j estimate).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_valid/s_ready/s_sof      input handshake and start-of-symbol marker
//   s_i, s_q                   signed input sample
//   est_rd, est_addr           estimate RAM read (data returns one cycle later)
//   est_i, est_q               estimate RAM data
//   div_i/div_q, div_est_*     numerator and estimate to the divider core
//   div_eq_i, div_eq_q         divider quotient, DIV_LAT cycles after div_* inputs
//   m_valid/m_i/m_q/m_idx      equalised output beat (no backpressure)
//   m_eos, m_zero              last subcarrier / zero-estimate flag
//   busy, err_sof, sym_cnt     status: not idle, protocol error pulse, completed symbols
module eq_div_sched
    import eq_pkg::*;
#(
    parameter int unsigned NSC     = NSC_DEF,
    parameter int unsigned IDX_W   = IDX_W_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_sof,
    input  logic [31:0]      s_i,
    input  logic [31:0]      s_q,
    output logic             est_rd,
    output logic [IDX_W-1:0] est_addr,
    input  logic [31:0]      est_i,
    input  logic [31:0]      est_q,
    output logic [31:0]      div_i,
    output logic [31:0]      div_q,
    output logic [31:0]      div_est_i,
    output logic [31:0]      div_est_q,
    input  logic [63:0]      div_eq_i,
    input  logic [63:0]      div_eq_q,
    output logic             m_valid,
    output logic [63:0]      m_i,
    output logic [63:0]      m_q,
    output logic [IDX_W-1:0] m_idx,
    output logic             m_eos,
    output logic             m_zero,
    output logic             busy,
    output logic             err_sof,
    output logic [15:0]      sym_cnt
);

    localparam int unsigned       PIPE     = pipe_depth(DIV_LAT);
    // Stages 1 and 2 live here because stage 2 is where the zero flag is attached.
    localparam int unsigned       TAIL     = PIPE - 2;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NSC - 1);

    state_e           r_state, w_state_d;
    logic [IDX_W-1:0] r_idx, w_idx_d, w_cur_idx;
    logic             r_ready, r_err, r_est_rd;
    logic [IDX_W-1:0] r_est_addr;
    logic [15:0]      r_sym_cnt;
    logic             w_xfer, w_accept, w_bad, w_last, w_sym_inc;

    tag_t             r_s1_tag, r_s2_tag, w_s1_tag, w_s3_tag, w_out, w_unused_tag;
    logic [31:0]      r_s1_i, r_s1_q, r_s2_i, r_s2_q;
    logic [31:0]      r_div_i, r_div_q, r_div_est_i, r_div_est_q;
    logic             w_est_zero;

    logic [63:0]      r_m_i, r_m_q, w_beat_i, w_beat_q;
    logic [IDX_W-1:0] r_m_idx;
    logic             r_m_eos;

    assign w_xfer    = s_valid && r_ready;
    // Index 0 is implied in IDLE; r_idx only matters once a symbol is open.
    assign w_cur_idx = (r_state == IDLE) ? '0 : r_idx;
    assign w_last    = (w_cur_idx == LAST_IDX);

    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_accept  = 1'b0;
        w_bad     = 1'b0;
        w_sym_inc = 1'b0;
        unique case (r_state)
            IDLE, RUN: begin
                if (w_xfer) begin
                    // IDLE needs sof to open a symbol; RUN refuses sof (no restart).
                    if (s_sof == (r_state == IDLE)) begin
                        w_accept  = 1'b1;
                        w_idx_d   = w_cur_idx + IDX_W'(1);
                        w_state_d = w_last ? DRAIN : RUN;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // The last tag at the output is the final occupant of the pipeline.
                if (w_out.valid && w_out.last) begin
                    w_state_d = IDLE;
                    w_sym_inc = 1'b1;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_comb begin
        w_s1_tag       = '0;
        w_s1_tag.valid = w_accept;
        w_s1_tag.idx   = TAG_IDX_W'(w_cur_idx);
        w_s1_tag.last  = w_last;
    end

    always_comb begin
        w_s3_tag      = r_s2_tag;
        w_s3_tag.zero = w_est_zero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_est_rd    <= 1'b0;
            r_est_addr  <= '0;
            r_sym_cnt   <= '0;
            r_s1_tag    <= '0;
            r_s2_tag    <= '0;
            r_s1_i      <= '0;
            r_s1_q      <= '0;
            r_s2_i      <= '0;
            r_s2_q      <= '0;
            r_div_i     <= '0;
            r_div_q     <= '0;
            r_div_est_i <= '0;
            r_div_est_q <= '0;
        end else begin
            r_state     <= w_state_d;
            r_idx       <= w_idx_d;
            r_ready     <= (w_state_d != DRAIN);
            r_err       <= w_bad;
            r_est_rd    <= w_accept;
            if (w_accept) begin
                r_est_addr <= w_cur_idx;
            end
            if (w_sym_inc) begin
                r_sym_cnt <= r_sym_cnt + 16'd1;
            end
            r_s1_tag    <= w_s1_tag;
            r_s1_i      <= s_i;
            r_s1_q      <= s_q;
            r_s2_tag    <= r_s1_tag;
            r_s2_i      <= r_s1_i;
            r_s2_q      <= r_s1_q;
            r_div_i     <= r_s2_i;
            r_div_q     <= r_s2_q;
            r_div_est_i <= est_i;
            r_div_est_q <= est_q;
        end
    end

    eq_tag_pipe #(
        .DEPTH (TAIL)
    ) u_tag_pipe (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_tag   (w_s3_tag),
        .o_tag   (w_out)
    );

    // Quotient arrives combinationally in the same cycle as its tag.
    always_comb begin
        w_beat_i = div_eq_i;
        w_beat_q = div_eq_q;
`ifdef EQ_ZERO_GUARD_EN
        if (w_out.zero) begin
            w_beat_i = '0;
            w_beat_q = '0;
        end
`endif
    end

`ifdef EQ_ZERO_GUARD_EN
    assign w_est_zero = (est_i == '0) && (est_q == '0);
    assign m_zero     = w_out.valid && w_out.zero;
`else
    assign w_est_zero = 1'b0;
    assign m_zero     = 1'b0;
`endif

    // Hold registers keep the last beat visible while m_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_i   <= '0;
            r_m_q   <= '0;
            r_m_idx <= '0;
            r_m_eos <= 1'b0;
        end else if (w_out.valid) begin
            r_m_i   <= w_beat_i;
            r_m_q   <= w_beat_q;
            r_m_idx <= w_out.idx[IDX_W-1:0];
            r_m_eos <= w_out.last;
        end
    end

    assign w_unused_tag = w_out;

    assign s_ready   = r_ready;
    assign est_rd    = r_est_rd;
    assign est_addr  = r_est_addr;
    assign div_i     = r_div_i;
    assign div_q     = r_div_q;
    assign div_est_i = r_div_est_i;
    assign div_est_q = r_div_est_q;
    assign m_valid   = w_out.valid;
    assign m_i       = w_out.valid ? w_beat_i : r_m_i;
    assign m_q       = w_out.valid ? w_beat_q : r_m_q;
    assign m_idx     = w_out.valid ? w_out.idx[IDX_W-1:0] : r_m_idx;
    assign m_eos     = w_out.valid ? w_out.last : r_m_eos;
    assign busy      = (r_state != IDLE);
    assign err_sof   = r_err;
    assign sym_cnt   = r_sym_cnt;

endmodule

// File: tb/tb_eq_div_sched.sv
// Scoreboard bench for eq_div_sched (NSC=4, DIV_LAT=8). The stimulus thread pushes expected
// beats and RAM addresses computed from the symbol rules; monitors pop and compare them.
`timescale 1ns/1ps
module tb_eq_div_sched;

    localparam int unsigned NSC     = 4;
    localparam int unsigned IDX_W   = 6;
    localparam int unsigned DIV_LAT = 8;
    localparam int unsigned PIPE    = 3 + DIV_LAT;

    logic             clk;
    logic             rst_n;
    logic             s_valid, s_ready, s_sof;
    logic [31:0]      s_i, s_q;
    logic             est_rd;
    logic [IDX_W-1:0] est_addr;
    logic [31:0]      est_i, est_q;
    logic [31:0]      div_i, div_q, div_est_i, div_est_q;
    logic [63:0]      div_eq_i, div_eq_q;
    logic             m_valid, m_eos, m_zero, busy, err_sof;
    logic [63:0]      m_i, m_q;
    logic [IDX_W-1:0] m_idx;
    logic [15:0]      sym_cnt;

    eq_div_sched #(
        .NSC     (NSC),
        .IDX_W   (IDX_W),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_sof     (s_sof),
        .s_i       (s_i),
        .s_q       (s_q),
        .est_rd    (est_rd),
        .est_addr  (est_addr),
        .est_i     (est_i),
        .est_q     (est_q),
        .div_i     (div_i),
        .div_q     (div_q),
        .div_est_i (div_est_i),
        .div_est_q (div_est_q),
        .div_eq_i  (div_eq_i),
        .div_eq_q  (div_eq_q),
        .m_valid   (m_valid),
        .m_i       (m_i),
        .m_q       (m_q),
        .m_idx     (m_idx),
        .m_eos     (m_eos),
        .m_zero    (m_zero),
        .busy      (busy),
        .err_sof   (err_sof),
        .sym_cnt   (sym_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] i;
        logic [63:0] q;
    } cpx_t;

    typedef struct {
        int unsigned idx;
        bit          eos;
        bit          zero;
        logic [63:0] qi;
        logic [63:0] qq;
        longint      edge_no;
    } beat_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    longint      cyc      = 0;
    beat_t       exp_q[$];
    int unsigned addr_q[$];
    logic [31:0] mem_i [NSC];
    logic [31:0] mem_q [NSC];
    cpx_t        div_pipe [DIV_LAT];

    // Reference-model state.
    bit          in_sym  = 0;
    int unsigned nxt_idx = 0;
    int          err_exp = 0;
    int          err_seen = 0;
    int          sym_exp = 0;
    bit          sym_pend = 0;
    logic [63:0] last_i = '0, last_q = '0;
    int unsigned last_idx = 0;
    bit          last_eos = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // num * conj(est) / |est|^2 in plain integer arithmetic; 0+0j gives all ones.
    function automatic cpx_t cdiv(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] c, input logic [31:0] d);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint sc = longint'($signed(c));
        longint sd = longint'($signed(d));
        longint den = sc * sc + sd * sd;
        cpx_t   r;
        if (den == 0) begin
            r.i = '1;
            r.q = '1;
        end else begin
            r.i = 64'((sa * sc + sb * sd) / den);
            r.q = 64'((sb * sc - sa * sd) / den);
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Estimate RAM: one-cycle read latency.
    always @(posedge clk) begin
        if (est_rd) begin
            est_i <= mem_i[est_addr];
            est_q <= mem_q[est_addr];
        end
    end

    // Divider core model: fixed DIV_LAT latency from div_* to div_eq_*.
    always @(posedge clk) begin
        div_pipe[0] <= cdiv(div_i, div_q, div_est_i, div_est_q);
        for (int k = 1; k < int'(DIV_LAT); k++) div_pipe[k] <= div_pipe[k-1];
    end
    assign div_eq_i = div_pipe[DIV_LAT-1].i;
    assign div_eq_q = div_pipe[DIV_LAT-1].q;

    // Output / status monitor.
    always @(negedge clk) begin
        beat_t b;
        if (rst_n) begin
            if (sym_pend) begin
                chk("sym_cnt", 64'(sym_cnt), 64'(sym_exp));
                sym_pend = 0;
            end
            if (err_sof) err_seen++;
            if (est_rd) begin
                if (addr_q.size() == 0) chk("spurious_est_rd", 64'(est_rd), 64'd0);
                else chk("est_addr", 64'(est_addr), 64'(addr_q.pop_front()));
            end
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_m_valid", 64'(m_valid), 64'd0);
                end else begin
                    b = exp_q.pop_front();
                    chk("latency", 64'(cyc), 64'(b.edge_no + PIPE - 1));
                    chk("m_idx", 64'(m_idx), 64'(b.idx));
                    chk("m_eos", 64'(m_eos), 64'(b.eos));
                    chk("m_zero", 64'(m_zero), 64'(b.zero));
                    chk("m_i", m_i, b.qi);
                    chk("m_q", m_q, b.qq);
                    last_i = b.qi; last_q = b.qq; last_idx = b.idx; last_eos = b.eos;
                    if (b.eos) begin
                        sym_exp++;
                        sym_pend = 1;
                    end
                end
            end else begin
                chk("hold_m_i", m_i, last_i);
                chk("hold_m_q", m_q, last_q);
                chk("hold_m_idx", 64'(m_idx), 64'(last_idx));
                chk("hold_m_eos", 64'(m_eos), 64'(last_eos));
                chk("idle_m_zero", 64'(m_zero), 64'd0);
            end
        end
    end

    // Symbol rules applied to one accepted transfer at posedge number edge_no.
    task automatic model_accept(input bit sof, input logic [31:0] si, input logic [31:0] sq,
                                input longint edge_no);
        beat_t b;
        cpx_t  r;
        if (in_sym == sof) begin
            err_exp++;
            return;
        end
        if (!in_sym) begin
            in_sym  = 1;
            nxt_idx = 0;
        end
        b.idx     = nxt_idx;
        b.eos     = (nxt_idx == NSC - 1);
        b.edge_no = edge_no;
        r = cdiv(si, sq, mem_i[nxt_idx], mem_q[nxt_idx]);
`ifdef EQ_ZERO_GUARD_EN
        b.zero = (mem_i[nxt_idx] == 0) && (mem_q[nxt_idx] == 0);
`else
        b.zero = 0;
`endif
        b.qi = b.zero ? 64'd0 : r.i;
        b.qq = b.zero ? 64'd0 : r.q;
        exp_q.push_back(b);
        addr_q.push_back(nxt_idx);
        nxt_idx++;
        if (b.eos) in_sym = 0;
    endtask

    // Called at a negedge; returns at the negedge following the transfer.
    task automatic send(input bit sof, input logic [31:0] si, input logic [31:0] sq);
        int n = 0;
        s_valid = 1; s_sof = sof; s_i = si; s_q = sq;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("ready_timeout", 64'(s_ready), 64'd1);
        else model_accept(sof, si, sq, cyc + 1);
        @(negedge clk);
        s_valid = 0; s_sof = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_quiet();
        int n = 0;
        while ((exp_q.size() != 0 || !s_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", 64'(exp_q.size()), 64'd0);
        idle(2);
    endtask

    task automatic set_est(input int ei, input int eq);
        for (int k = 0; k < int'(NSC); k++) begin
            mem_i[k] = ei;
            mem_q[k] = eq;
        end
    endtask

    task automatic reset_checks();
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_est_rd", 64'(est_rd), 64'd0);
        chk("rst_est_addr", 64'(est_addr), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_eos", 64'(m_eos), 64'd0);
        chk("rst_m_zero", 64'(m_zero), 64'd0);
        chk("rst_err_sof", 64'(err_sof), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sym_cnt", 64'(sym_cnt), 64'd0);
        chk("rst_div_i", 64'(div_i), 64'd0);
        chk("rst_m_i", m_i, 64'd0);
        chk("rst_m_idx", 64'(m_idx), 64'd0);
    endtask

    function automatic logic [31:0] rnd(input int span);
        return 32'(int'($urandom_range(0, 2 * span)) - span);
    endfunction

    initial begin
        rst_n = 0; s_valid = 0; s_sof = 0; s_i = '0; s_q = '0;
        est_i = '0; est_q = '0;
        set_est(1, 1);
        for (int k = 0; k < int'(DIV_LAT); k++) div_pipe[k] = '0;
        idle(3);
        reset_checks();
        rst_n = 1;
        idle(2);

        // s = (2+2j)k against est = 1+1j: quotient 2k + 0j.
        for (int k = 1; k <= int'(NSC); k++) begin
            send(k == 1, 32'(2 * k), 32'(2 * k));
            if (k == 2) chk("busy_run", 64'(busy), 64'd1);
        end
        wait_quiet();
        chk("busy_idle", 64'(busy), 64'd0);

        // Stray sample in IDLE: dropped with one err pulse.
        send(0, 32'd7, 32'd7);
        idle(3);
        chk("err_idle", 64'(err_seen), 64'(err_exp));

        // Gapped symbol.
        set_est(3, -2);
        for (int k = 0; k < int'(NSC); k++) begin
            send(k == 0, rnd(1000), rnd(1000));
            idle(1);
        end
        wait_quiet();

        // sof in the middle of a symbol is dropped; the symbol still closes after NSC samples.
        send(1, 32'd10, 32'd20);
        send(0, 32'd30, 32'd40);
        send(1, 32'd99, 32'd99);
        send(0, 32'd50, 32'd60);
        send(0, 32'd70, 32'd80);
        wait_quiet();
        chk("err_run", 64'(err_seen), 64'(err_exp));

        // Zero estimate at index 1.
        set_est(5, 4);
        mem_i[1] = 0; mem_q[1] = 0;
        for (int k = 0; k < int'(NSC); k++) send(k == 0, rnd(5000), rnd(5000));
        wait_quiet();

        // Random symbols with random gaps and occasional stray sof.
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < int'(NSC); k++) begin
                mem_i[k] = rnd(1000);
                mem_q[k] = rnd(1000);
                if (mem_i[k] == 0 && mem_q[k] == 0) mem_i[k] = 1;
            end
            for (int k = 0; k < int'(NSC); k++) begin
                if (k > 0 && $urandom_range(0, 7) == 0) send(1, rnd(9), rnd(9));
                send(k == 0, rnd(100000), rnd(100000));
                idle(int'($urandom_range(0, 2)));
            end
            wait_quiet();
        end
        chk("err_rand", 64'(err_seen), 64'(err_exp));

        // Reset after the second accept: in-flight beats must vanish.
        send(1, 32'd1, 32'd2);
        send(0, 32'd3, 32'd4);
        #2;
        rst_n = 0;
        exp_q.delete();
        addr_q.delete();
        in_sym = 0; sym_exp = 0; sym_pend = 0;
        last_i = '0; last_q = '0; last_idx = 0; last_eos = 0;
        idle(2);
        reset_checks();
        rst_n = 1;
        idle(1);
        set_est(2, 0);
        for (int k = 0; k < int'(NSC); k++) send(k == 0, rnd(3000), rnd(3000));
        wait_quiet();
        idle(PIPE + 4);
        chk("sym_after_reset", 64'(sym_cnt), 64'd1);
        chk("final_queue", 64'(exp_q.size() + addr_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
